// File: rtl/bcd2binary_seq_pkg.sv
// Shared types and elaboration helpers for the sequential BCD-to-binary converter.
package bcd2binary_seq_pkg;

  // Converter FSM: waiting for a request, or folding in one digit per clock.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  localparam int unsigned NIBBLE_W  = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;

  // Smallest binary width w with 2^w > 10^digits - 1 (i.e. 2^w >= 10^digits).
  function automatic int bin_w_min(input int digits);
    longint unsigned limit;
    int              w;
    limit = 64'd1;
    for (int i = 0; i < digits; i++) begin
      limit = limit * 64'd10;
    end
    w = 0;
    while ((64'd1 << w) < limit) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Digit counter width; a single-digit converter still needs a 1-bit counter.
  function automatic int cnt_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd2binary_seq_digit_mac.sv
// One Horner step of the conversion: nxt = acc*10 + d (wrapping), bad = (d > 9).
module bcd_digit_mac
  import bcd2binary_seq_pkg::*;
#(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       d,
  output logic [BIN_W-1:0] nxt,
  output logic             bad
);

  logic [BIN_W+3:0] acc_ext_s;
  logic [BIN_W+3:0] d_ext_s;
  logic [BIN_W+3:0] sum_s;

  // Multiply-by-ten as shift-and-add in a widened word, then truncate to BIN_W.
  always_comb begin
    acc_ext_s = {4'b0000, acc};
    d_ext_s   = {{BIN_W{1'b0}}, d};
    sum_s     = (acc_ext_s << 3'd3) + (acc_ext_s << 3'd1) + d_ext_s;
    nxt       = sum_s[BIN_W-1:0];
    bad       = (d > MAX_DIGIT);
  end

endmodule

// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first,
// with a start/busy/done handshake and invalid-digit flagging.
module bcd2binary_seq
  import bcd2binary_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binario,
  output logic                  error
);

  localparam int CNT_W = cnt_w(DIGITS);

  if (DIGITS < 1) begin : g_digits_chk
    $error("bcd2binary_seq: DIGITS must be at least 1");
  end
  if (BIN_W < bin_w_min(DIGITS)) begin : g_bin_w_chk
    $error("bcd2binary_seq: BIN_W too small to hold 10^DIGITS-1");
  end

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [4*DIGITS-1:0]   sreg_q,    sreg_d;
  logic [BIN_W-1:0]      acc_q,     acc_d;
  logic                  err_acc_q, err_acc_d;
  logic [BIN_W-1:0]      binario_q, binario_d;
  logic                  error_q,   error_d;
  logic                  done_q,    done_d;

  logic [3:0]            digit_s;
  logic [BIN_W-1:0]      mac_nxt_s;
  logic                  mac_bad_s;
  logic                  last_s;
  logic                  err_any_s;

  // The digit being consumed is always the top nibble of the shift register.
  assign digit_s = sreg_q[4*DIGITS-1 -: NIBBLE_W];

  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc (acc_q),
    .d   (digit_s),
    .nxt (mac_nxt_s),
    .bad (mac_bad_s)
  );

  assign last_s    = (cnt_q == CNT_W'(DIGITS - 1));
  assign err_any_s = err_acc_q | mac_bad_s;

  // Next-state and datapath updates; every register holds unless told otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    err_acc_d = err_acc_q;
    binario_d = binario_q;
    error_d   = error_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d    = bcd;
          acc_d     = {BIN_W{1'b0}};
          err_acc_d = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_CONV;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CONV: begin
        acc_d     = mac_nxt_s;
        err_acc_d = err_any_s;
        sreg_d    = sreg_q << 3'd4;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_s) begin
          // An invalid digit anywhere forces a zero result so garbage never escapes.
          binario_d = err_any_s ? {BIN_W{1'b0}} : mac_nxt_s;
          error_d   = err_any_s;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_CONV;
        end
      end
      default: begin
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      sreg_q    <= {(4*DIGITS){1'b0}};
      acc_q     <= {BIN_W{1'b0}};
      err_acc_q <= 1'b0;
      binario_q <= {BIN_W{1'b0}};
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      err_acc_q <= err_acc_d;
      binario_q <= binario_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == ST_CONV);
  assign done    = done_q;
  assign binario = binario_q;
  assign error   = error_q;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Scoreboard bench for bcd2binary_seq: a 2-digit and a 4-digit instance share
// clock and reset; expected results come from a plain-arithmetic reference.
module tb_bcd2binary_seq;

  typedef struct {
    int unsigned val;
    bit          err;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        start2;
  logic [7:0]  bcd2;
  logic        busy2, done2, error2;
  logic [6:0]  bin2;

  logic        start4;
  logic [15:0] bcd4;
  logic        busy4, done4, error4;
  logic [13:0] bin4;

  int          checks   = 0;
  int          failures = 0;

  exp_t        q2[$];
  exp_t        q4[$];
  int unsigned cyc = 0;
  int          rem2 = 0;
  int          rem4 = 0;
  int unsigned last_val2 = 0, last_val4 = 0;
  bit          last_err2 = 1'b0, last_err4 = 1'b0;

  always #5 clk = ~clk;

  bcd2binary_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .bcd(bcd2),
    .busy(busy2), .done(done2), .binario(bin2), .error(error2)
  );

  bcd2binary_seq #(.DIGITS(4), .BIN_W(14)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .bcd(bcd4),
    .busy(busy4), .done(done4), .binario(bin4), .error(error4)
  );

  // Reference: decimal value of the digits, zero if any digit exceeds 9.
  function automatic void ref_conv(input logic [63:0] word, input int nd, input int bw,
                                   output int unsigned val, output bit err);
    longint unsigned v;
    int              d;
    v   = 0;
    err = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((word >> (4 * i)) & 64'hF);
      if (d > 9) err = 1'b1;
      v = v * 10 + longint'(d);
    end
    val = err ? 0 : int'(v % (longint'(1) << bw));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request model: accepts start only when idle, predicts result and done cycle.
  always @(posedge clk or posedge reset) begin : model
    exp_t e;
    if (reset) begin
      rem2 = 0;
      rem4 = 0;
      q2.delete();
      q4.delete();
      last_val2 = 0; last_err2 = 1'b0;
      last_val4 = 0; last_err4 = 1'b0;
    end else begin
      cyc++;
      if (rem2 == 0 && start2) begin
        ref_conv(64'(bcd2), 2, 7, e.val, e.err);
        e.due = cyc + 2;
        q2.push_back(e);
        rem2 = 2;
      end else if (rem2 > 0) begin
        rem2--;
      end
      if (rem4 == 0 && start4) begin
        ref_conv(64'(bcd4), 4, 14, e.val, e.err);
        e.due = cyc + 4;
        q4.push_back(e);
        rem4 = 4;
      end else if (rem4 > 0) begin
        rem4--;
      end
    end
  end

  // Monitor: compares outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      chk("busy2", 64'(busy2), 64'(rem2 > 0));
      chk("busy4", 64'(busy4), 64'(rem4 > 0));
      if (done2) begin
        if (q2.size() == 0) begin
          chk("done2_unexpected", 64'(done2), 64'd0);
        end else begin
          e = q2.pop_front();
          chk("bin2", 64'(bin2), 64'(e.val));
          chk("err2", 64'(error2), 64'(e.err));
          chk("latency2", 64'(cyc), 64'(e.due));
          last_val2 = e.val;
          last_err2 = e.err;
        end
      end else begin
        chk("hold_bin2", 64'(bin2), 64'(last_val2));
        chk("hold_err2", 64'(error2), 64'(last_err2));
        if (q2.size() > 0 && q2[0].due == cyc) begin
          chk("done2_missing", 64'(done2), 64'd1);
          void'(q2.pop_front());
        end
      end
      if (done4) begin
        if (q4.size() == 0) begin
          chk("done4_unexpected", 64'(done4), 64'd0);
        end else begin
          e = q4.pop_front();
          chk("bin4", 64'(bin4), 64'(e.val));
          chk("err4", 64'(error4), 64'(e.err));
          chk("latency4", 64'(cyc), 64'(e.due));
          last_val4 = e.val;
          last_err4 = e.err;
        end
      end else begin
        chk("hold_bin4", 64'(bin4), 64'(last_val4));
        chk("hold_err4", 64'(error4), 64'(last_err4));
        if (q4.size() > 0 && q4[0].due == cyc) begin
          chk("done4_missing", 64'(done4), 64'd1);
          void'(q4.pop_front());
        end
      end
    end
  end

  task automatic conv2(input logic [7:0] v);
    bcd2   = v;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic conv4(input logic [15:0] v);
    bcd4   = v;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bin2"},  64'(bin2),   64'd0);
    chk({tag, "_err2"},  64'(error2), 64'd0);
    chk({tag, "_busy2"}, 64'(busy2),  64'd0);
    chk({tag, "_done2"}, 64'(done2),  64'd0);
    chk({tag, "_bin4"},  64'(bin4),   64'd0);
    chk({tag, "_err4"},  64'(error4), 64'd0);
    chk({tag, "_busy4"}, 64'(busy4),  64'd0);
    chk({tag, "_done4"}, 64'(done4),  64'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start2 = 1'b0;
    bcd2   = 8'h00;
    start4 = 1'b0;
    bcd4   = 16'h0000;
    #2;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Every valid 2-digit code, back to back.
    for (int t = 0; t < 100; t++) begin
      conv2({4'(t / 10), 4'(t % 10)});
    end

    // Invalid digits then recovery.
    conv2(8'h1A);
    conv2(8'hF0);
    conv2(8'h42);

    // Arbitrary bytes, including invalid nibbles.
    for (int t = 0; t < 30; t++) begin
      conv2(8'($urandom));
    end

    // Four-digit corner values and random words.
    conv4(16'h9999);
    conv4(16'h0000);
    conv4(16'h1024);
    for (int t = 0; t < 20; t++) begin
      conv4(16'($urandom));
    end
    conv4(16'h7531);

    // start re-pulsed and bcd changed while busy must be ignored.
    bcd2   = 8'h37;
    start2 = 1'b1;
    @(negedge clk);
    bcd2   = 8'h55;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bcd2   = 8'h99;
    repeat (4) @(negedge clk);

    // Reset during the second CONV cycle aborts without a done.
    bcd4   = 16'h9876;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    conv4(16'h0815);
    conv2(8'h63);

    // start held high: a new conversion accepted every DIGITS+1 cycles.
    start2 = 1'b1;
    start4 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      bcd2 = 8'($urandom);
      bcd4 = 16'($urandom);
      @(negedge clk);
    end
    start2 = 1'b0;
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q4_drained", 64'(q4.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
